// File: rtl/nios_system_entity_ctrl_out_if.sv
// Avalon-MM slave bus bundle for the entity control output port.
//
// Bus semantics: there is no valid/ready pair. A write is accepted
// unconditionally at the clk edge where chipselect=1 and write_n=0. readdata
// is registered every edge from the current address (no read strobe) and is
// valid one cycle after the address is presented.
interface nios_system_entity_ctrl_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_entity_ctrl_out.sv
// Entity control output port: level register with atomic set/clear,
// timed one-shot pulse register, and a one-cycle update strobe raised
// whenever the level register actually changes value.
module nios_system_entity_ctrl_out #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios_system_entity_ctrl_out_if.slave bus,
    output logic [WIDTH-1:0]             out_port,
    output logic [WIDTH-1:0]             pulse_port,
    output logic                         update_strobe
);

    localparam int               CNT_W      = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PULSE    = 3'd1;
    localparam logic [2:0] ADDR_COUNT    = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] pulse_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] wmask;
    logic             wr_en;
    logic             pulse_load;
    logic [31:0]      rd_mux;

    // Upper writedata bits beyond WIDTH are deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign wr_en      = bus.chipselect && !bus.write_n;
    assign wmask      = bus.writedata[WIDTH-1:0];
    assign pulse_load = wr_en && (bus.address == ADDR_PULSE) && (|wmask);

    // Next level value from DATA / OUTSET / OUTCLEAR writes.
    always_comb begin
        data_next = data_reg;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_next = wmask;
                ADDR_OUTSET:   data_next = data_reg | wmask;
                ADDR_OUTCLEAR: data_next = data_reg & ~wmask;
                default:       data_next = data_reg;
            endcase
        end
    end

    // Level register and its change strobe (strobe only on a real change).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg      <= RESET_VALUE;
            update_strobe <= 1'b0;
        end else begin
            data_reg      <= data_next;
            update_strobe <= (data_next != data_reg);
        end
    end

    // Pulse bits and countdown; a nonzero write reloads the count and wins
    // over the final expiry tick, so overlapping pulses never show a gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_reg <= '0;
            cnt       <= '0;
        end else if (pulse_load) begin
            pulse_reg <= pulse_reg | wmask;
            cnt       <= PULSE_LOAD;
        end else if (cnt > CNT_ONE) begin
            cnt       <= cnt - CNT_ONE;
        end else if (cnt == CNT_ONE) begin
            cnt       <= '0;
            pulse_reg <= '0;
        end
    end

    // Read mux on the current address, zero-extended.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:  rd_mux[WIDTH-1:0] = data_reg;
            ADDR_PULSE: rd_mux[WIDTH-1:0] = pulse_reg;
            ADDR_COUNT: rd_mux[CNT_W-1:0] = cnt;
            default:    rd_mux = '0;
        endcase
    end

    // Registered read data, refreshed every edge regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign out_port   = data_reg;
    assign pulse_port = pulse_reg;

endmodule

// File: tb/tb_nios_system_entity_ctrl_out.sv
// Self-checking bench for nios_system_entity_ctrl_out (default parameters).
module tb_nios_system_entity_ctrl_out;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] pulse_port;
    logic             update_strobe;

    nios_system_entity_ctrl_out_if bus ();

    nios_system_entity_ctrl_out #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (8'h00),
        .PULSE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .out_port     (out_port),
        .pulse_port   (pulse_port),
        .update_strobe(update_strobe)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    // One write accepted at the next edge; bus released right after it.
    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus_idle();
    endtask

    // Present an address, push the expectation, compare after the edge.
    task automatic rd(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        exp_q.push_back(exp);
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.readdata, e);
        end
    endtask

    // Two overlapping pulses with `gap` idle edges between the writes.
    task automatic pulse_overlap(input int gap, input string tag);
        wr(3'd1, 32'h01);
        check({tag, "_first"}, 32'(pulse_port), 32'h01);
        for (int i = 0; i < gap; i++) begin
            tick();
            check({tag, "_first_hold"}, 32'(pulse_port), 32'h01);
        end
        wr(3'd1, 32'h10);
        check({tag, "_merged"}, 32'(pulse_port), 32'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_merged_hold"}, 32'(pulse_port), 32'h11);
        end
        tick();
        check({tag, "_end"}, 32'(pulse_port), 32'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n     = 1'b0;
        bus.address = 3'd0;
        bus_idle();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // Reset state.
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_pulse", 32'(pulse_port), 32'h0);
        check("rst_strobe", 32'(update_strobe), 32'h0);
        rd("rst_rd0", 3'd0, 32'h0);
        rd("rst_rd1", 3'd1, 32'h0);
        rd("rst_rd2", 3'd2, 32'h0);

        // DATA write, upper bits ignored, strobe exactly one cycle.
        wr(3'd0, 32'h1A5);
        m_data = 8'hA5;
        check("data_out", 32'(out_port), 32'hA5);
        check("data_strobe", 32'(update_strobe), 32'h1);
        tick();
        check("data_strobe_off", 32'(update_strobe), 32'h0);
        rd("data_rd", 3'd0, 32'h000000A5);
        wr(3'd0, 32'hA5);
        check("rewrite_nostrobe", 32'(update_strobe), 32'h0);
        check("rewrite_out", 32'(out_port), 32'hA5);

        // OUTSET then OUTCLEAR on consecutive edges.
        wr(3'd4, 32'h0A);
        check("set_out", 32'(out_port), 32'hAF);
        check("set_strobe", 32'(update_strobe), 32'h1);
        wr(3'd5, 32'h81);
        m_data = 8'h2E;
        check("clr_out", 32'(out_port), 32'h2E);
        check("clr_strobe", 32'(update_strobe), 32'h1);
        tick();
        check("clr_strobe_off", 32'(update_strobe), 32'h0);
        rd("rd_addr4", 3'd4, 32'h0);
        rd("rd_addr5", 3'd5, 32'h0);

        // Unmapped address: write ignored, reads 0.
        wr(3'd3, 32'hFF);
        check("addr3_nostrobe", 32'(update_strobe), 32'h0);
        check("addr3_out", 32'(out_port), 32'h2E);
        rd("rd_addr3", 3'd3, 32'h0);
        rd("rd_addr7", 3'd7, 32'h0);

        // Zero-mask pulse write has no effect.
        wr(3'd1, 32'h100);
        check("pulse_zero_mask", 32'(pulse_port), 32'h0);

        // Single pulse, count readback 4,3,2,1,0.
        wr(3'd1, 32'h03);
        check("pulse_start", 32'(pulse_port), 32'h03);
        for (int i = 0; i < 5; i++) begin
            rd("pulse_cnt", 3'd2, 32'(4 - i));
            check("pulse_level", 32'(pulse_port), (i < 3) ? 32'h03 : 32'h00);
        end

        // Overlapping pulses: mid-count and exactly on the cnt==1 edge.
        pulse_overlap(2, "ovl_mid");
        pulse_overlap(3, "ovl_last");

        // Random level writes against a small model.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] v;
            logic [7:0] nxt;
            logic [2:0] a;
            int         op;
            op = $urandom_range(0, 2);
            v  = 8'($urandom_range(0, 255));
            case (op)
                0:       begin a = 3'd0; nxt = v;           end
                1:       begin a = 3'd4; nxt = m_data | v;  end
                default: begin a = 3'd5; nxt = m_data & ~v; end
            endcase
            wr(a, {24'hABCDEF, v});
            check("rand_out", 32'(out_port), 32'(nxt));
            check("rand_strobe", 32'(update_strobe), 32'(nxt != m_data));
            m_data = nxt;
        end

        // Asynchronous reset mid-pulse and mid-strobe.
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'hFF);
        if (m_data == 8'hFF) begin
            check("pre_rst_strobe", 32'(update_strobe), 32'h0);
        end else begin
            check("pre_rst_strobe", 32'(update_strobe), 32'h1);
        end
        m_data = 8'hFF;
        bus.address = 3'd0;
        tick();
        check("pre_rst_rd", bus.readdata, 32'hFF);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out", 32'(out_port), 32'h0);
        check("arst_pulse", 32'(pulse_port), 32'h0);
        check("arst_rd", bus.readdata, 32'h0);
        check("arst_strobe", 32'(update_strobe), 32'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        rd("post_rst_cnt", 3'd2, 32'h0);
        rd("post_rst_data", 3'd0, 32'h0);
        check("post_rst_pulse", 32'(pulse_port), 32'h0);

        if (exp_q.size() != 0) begin
            check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
